// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and state encoding for the 8x64 RAM burst initiator.
//   RAM_DW/RAM_AW/RAM_DEPTH describe the attached single-port RAM.
//   state_e is the initiator sequencer state.
package ram_pkg;
  localparam int RAM_DW    = 8;
  localparam int RAM_AW    = 6;
  localparam int RAM_DEPTH = 2 ** RAM_AW;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;
endpackage

// File: rtl/ram_burst_initiator_if.sv
// ram_burst_initiator_if: client command/data streams plus RAM-side bus of the burst initiator.
//   cmd_*   : burst command handshake (client -> initiator)
//   wr_*    : write beat stream (client -> initiator)
//   rd_*    : read beat stream (initiator -> client)
//   busy/done : burst status
//   ram_*   : single-port RAM access (initiator <-> RAM)
//   err     : rejected-command pulse, present only with RAM_BURST_BOUND_CHECK_EN
//   modport master = initiator side, slave = client/RAM side.
interface ram_burst_initiator_if
  import ram_pkg::*;
#(
  parameter int DW = RAM_DW,
  parameter int AW = RAM_AW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_out;
`ifdef RAM_BURST_BOUND_CHECK_EN
  logic          err;
`endif
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_out,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, ram_data, ram_addr, ram_write
`ifdef RAM_BURST_BOUND_CHECK_EN
    , output err
`endif
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, ram_data, ram_addr, ram_write
`ifdef RAM_BURST_BOUND_CHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/ram_burst_addr_gen.sv
// ram_burst_addr_gen: burst address pointer and remaining-beat counter.
//   load_i/addr_i/len_i : start a burst at addr_i with len_i+1 beats
//   adv_i               : one beat completed, step pointer (wraps mod 2**AW) and counter
//   ptr_o/ptr_nxt_o     : current beat address and the address after it
//   last_o              : current beat is the final one of the burst
module ram_burst_addr_gen
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] len_i,
  output logic [AW-1:0] ptr_o,
  output logic [AW-1:0] ptr_nxt_o,
  output logic          last_o
);
  logic [AW-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
  always_comb begin
    ptr_d = load_i ? addr_i : adv_i ? ptr_q + 1'b1 : ptr_q;
    cnt_d = load_i ? len_i  : adv_i ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign ptr_o     = ptr_q;
  assign ptr_nxt_o = ptr_q + 1'b1;
  assign last_o    = cnt_q == '0;
endmodule

// File: rtl/ram_burst_initiator.sv
// ram_burst_initiator: turns one burst command into per-cycle accesses of an 8x64 single-port RAM.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : ram_burst_initiator_if.master (command, write/read streams, status, RAM bus)
//   Optional macro RAM_BURST_BOUND_CHECK_EN rejects bursts running past the top address
//   and pulses bus.err instead of wrapping.
module ram_burst_initiator
  import ram_pkg::*;
#(
  parameter int DW = RAM_DW,
  parameter int AW = RAM_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_burst_initiator_if.master  bus
);
  state_e        state_q;
  logic          done_q, rd_valid_q;
  logic          req, oob, load, wr_acc, rd_acc, adv, last;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [DW-1:0] wdata, rdata;
`ifdef RAM_BURST_BOUND_CHECK_EN
  logic          err_q;
  logic [AW:0]   end_addr;
  assign end_addr = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign oob      = end_addr[AW];
  assign bus.err  = err_q;
`else
  assign oob = 1'b0;
`endif
  assign req    = state_q == IDLE && bus.cmd_valid;
  assign load   = req && !oob;
  assign wr_acc = state_q == WRITE && bus.wr_valid;
  assign rd_acc = rd_valid_q && bus.rd_ready;
  assign adv    = wr_acc || rd_acc;
  ram_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .adv_i     (adv),
    .addr_i    (bus.cmd_addr),
    .len_i     (bus.cmd_len),
    .ptr_o     (ptr),
    .ptr_nxt_o (ptr_nxt),
    .last_o    (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef RAM_BURST_BOUND_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q     <= adv && last;
      rd_valid_q <= state_q == READ && !(rd_acc && last);
`ifdef RAM_BURST_BOUND_CHECK_EN
      err_q      <= req && oob;
`endif
      unique case (state_q)
        IDLE:    if (load) state_q <= bus.cmd_write ? WRITE : READ;
        WRITE:   if (wr_acc && last) state_q <= IDLE;
        READ:    if (rd_acc && last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // In READ the RAM address runs one beat ahead of rd_data: on a completing beat the
  // next address is presented so beats stream back-to-back; on a stall the current
  // address is re-presented so the RAM output (and rd_data) stays put.
  assign wdata         = state_q == WRITE ? bus.wr_data : '0;
  assign rdata         = rd_valid_q ? bus.ram_out : '0;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.wr_ready  = state_q == WRITE;
  assign bus.ram_write = wr_acc;
  assign bus.ram_data  = wdata;
  assign bus.ram_addr  = state_q == IDLE ? '0 : rd_acc ? ptr_nxt : ptr;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rdata;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ram_burst_initiator.sv
// tb_ram_burst_initiator: scoreboard bench for ram_burst_initiator with a behavioural 8x64 RAM.
module tb_ram_burst_initiator;
  import ram_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ram_burst_initiator_if bus ();
  ram_burst_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [7:0]  mem [64];
  logic [5:0]  raddr_q;
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data;
    else raddr_q <= bus.ram_addr;
  end
  assign bus.ram_out = mem[raddr_q];

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [13:0] wq [$];
  logic [7:0]  rq [$];
  logic [7:0]  vec [64];
  logic [13:0] we;
  logic [7:0]  re;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.ram_write) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          we = wq.pop_front();
          chk("ram_write_addr", int'(bus.ram_addr), int'(we[13:8]));
          chk("ram_write_data", int'(bus.ram_data), int'(we[7:0]));
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          chk("rd_data", int'(bus.rd_data), int'(re));
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [5:0] a, input logic [5:0] l);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin
      cycle();
      n++;
    end
    if (n == 100) chk("cmd_ready_timeout", 0, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [5:0] a, input int n, input bit stall);
    int         crb = 0;
    int         d0 = done_cnt;
    logic [5:0] p = a;
    issue(1'b1, a, 6'(n - 1));
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        bus.wr_valid = 1'b0;
        chk("wr_stall_addr", int'(bus.ram_addr), int'(p));
        cycle();
      end
      crb += int'(bus.cmd_ready);
      bus.wr_valid = 1'b1;
      bus.wr_data  = vec[i];
      wq.push_back({p, vec[i]});
      cycle();
      p++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_cmd_ready_busy", crb, 0);
    chk("wr_done_pulse", int'(bus.done), 1);
    chk("wr_cmd_ready_with_done", int'(bus.cmd_ready), 1);
    cycle();
    chk("wr_done_low", int'(bus.done), 0);
    chk("wr_done_count", done_cnt - d0, 1);
  endtask

  task automatic rd_burst(input logic [5:0] a, input int n, input int sb, input int sc);
    int         beat = 0;
    int         cyc = 0;
    int         stalls = sc;
    int         crb = 0;
    int         d0 = done_cnt;
    logic [5:0] p;
    for (int i = 0; i < n; i++) rq.push_back(vec[i]);
    issue(1'b0, a, 6'(n - 1));
    while (beat < n && cyc < 300) begin
      crb += int'(bus.cmd_ready);
      if (bus.rd_valid && beat == sb && stalls > 0) begin
        bus.rd_ready = 1'b0;
        stalls--;
        #1;
        p = a + 6'(beat);
        chk("rd_stall_data", int'(bus.rd_data), int'(vec[beat]));
        chk("rd_stall_addr", int'(bus.ram_addr), int'(p));
      end else bus.rd_ready = 1'b1;
      if (bus.rd_valid && bus.rd_ready) beat++;
      cycle();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    chk("rd_cycles", cyc, n + 1 + sc);
    chk("rd_cmd_ready_busy", crb, 0);
    chk("rd_done_pulse", int'(bus.done), 1);
    chk("rd_cmd_ready_with_done", int'(bus.cmd_ready), 1);
    cycle();
    chk("rd_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    #2;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_ready", int'(bus.wr_ready), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ram_write", int'(bus.ram_write), 0);
    chk("rst_ram_addr", int'(bus.ram_addr), 0);
    chk("rst_ram_data", int'(bus.ram_data), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    issue(1'b1, 6'd0, 6'd8);
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = vec[i];
      wq.push_back({6'(i), vec[i]});
      cycle();
    end
    bus.wr_valid = 1'b0;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("midrst_done", int'(bus.done), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("midrst_no_done", done_cnt - d0, 0);
    rd_burst(6'd0, 3, 99, 0);

    vec[0] = 8'hA0; vec[1] = 8'hA1; vec[2] = 8'hA2; vec[3] = 8'hA3;
    wr_burst(6'd62, 4, 1'b0);
    rd_burst(6'd62, 4, 99, 0);

    vec[0] = 8'h31; vec[1] = 8'h32; vec[2] = 8'h33; vec[3] = 8'h34;
    wr_burst(6'd10, 4, 1'b1);
    rd_burst(6'd10, 4, 99, 0);

    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03;
    wr_burst(6'd0, 3, 1'b0);
    rd_burst(6'd0, 3, 1, 2);

    for (int i = 0; i < 64; i++) vec[i] = 8'(i) ^ 8'h5A;
    wr_burst(6'd17, 64, 1'b0);
    rd_burst(6'd17, 64, 99, 0);

`ifdef RAM_BURST_BOUND_CHECK_EN
    d0 = done_cnt;
    issue(1'b1, 6'd62, 6'd3);
    chk("oob_err_pulse", int'(bus.err), 1);
    chk("oob_cmd_ready", int'(bus.cmd_ready), 1);
    chk("oob_busy", int'(bus.busy), 0);
    cycle();
    chk("oob_err_low", int'(bus.err), 0);
    chk("oob_no_done", done_cnt - d0, 0);
`endif

    cycle();
    chk("write_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_burst_initiator.md
Name: ram_burst_initiator

Overview:
- Requester-side sequencer for the 8x64 single-port RAM: turns one burst command (start address, length, direction) into a series of per-cycle RAM accesses.
- Provides a valid/ready write-data stream and a valid/ready read-data stream to the client.
- Sits between a client (test engine or DMA-style user) and the RAM.
- RAM timing it drives: the RAM writes on the clock edge when write=1. When write=0 it registers the address, and its output shows that address's data in the following cycle.

Parameters:
- DW, 8, data width; must match the RAM word width.
- AW, 6, address width; the RAM depth is 2**AW = 64.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  initiator can accept a command (high only in IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  burst start address
- cmd_len  in  AW  beat count minus 1 (0 means 1 beat, 63 means 64 beats)
- wr_data  in  DW  write beat data
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted this cycle when wr_valid is also high
- rd_data  out  DW  read beat data
- rd_valid  out  1  read beat valid
- rd_ready  in  1  client accepts the read beat
- busy  out  1  a burst is in progress
- done  out  1  one-cycle pulse when the last beat of a burst completes
- ram_data  out  DW  to RAM data
- ram_addr  out  AW  to RAM addr
- ram_write  out  1  to RAM write
- ram_out  in  DW  from RAM out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, ram_write=0, ram_addr=0, ram_data=0.
  - The beat counter and address pointer clear.
  - A burst in progress is abandoned. Beats already written stay in the RAM. No done pulse is issued.
- States: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1, latch the start address into ptr and the length into cnt.
  - Go to WRITE if cmd_write=1, otherwise READ. busy rises in the next cycle.
- WRITE:
  - wr_ready=1; ram_addr=ptr; ram_data=wr_data; ram_write=wr_valid (combinational pass-through).
  - Each accepted beat increments ptr (modulo 64) and decrements cnt.
  - A beat accepted with cnt=0 is the last beat: done pulses in the next cycle and the state returns to IDLE.
  - wr_valid=0 stalls the burst without limit and without error.
- READ (ram_write=0 throughout):
  - Cycle k drives ram_addr=ptr. In cycle k+1 rd_valid=1 and rd_data=ram_out, so read latency is 1 cycle.
  - If rd_valid=1 and rd_ready=0, hold ram_addr at the current beat's address and hold the pointer and counter. The RAM re-registers the same address, so rd_data stays stable.
  - A beat completes when rd_valid and rd_ready are both high. After the final completed beat, done pulses and the state returns to IDLE.
  - Back-to-back operation: with rd_ready held high, one beat completes per cycle after the first-cycle latency.
- Wrap-around: ptr wraps from 63 to 0. A 64-beat burst covers every address exactly once.
- Commands presented while busy are not accepted (cmd_ready=0). The client holds cmd_valid.
- No transactions overlap. cmd_ready rises in the same cycle as done.

Optional Feature:
- Macro: RAM_BURST_BOUND_CHECK_EN.
- When defined:
  - A command with cmd_addr + cmd_len > 63 is rejected in IDLE.
  - The command is consumed (handshake completes), no RAM access occurs, and a new output err (1 bit, reset 0) pulses for one cycle.
  - done does not pulse for a rejected command.
- When undefined: the err port is absent and bursts wrap modulo 64.

Decomposition:
- Shared package ram_pkg holds:
  - the constants RAM_DW=8, RAM_AW=6, RAM_DEPTH=64;
  - a state enum type with IDLE, WRITE, READ.
- A single sub-module is natural: ram_burst_addr_gen, holding the ptr/cnt registers with load, advance, wrap and a last-beat flag.
- The handshake and state logic stay in the top module.

Test Plan:
- Reset mid-burst: start a write burst at address 0 with length 9 (cmd_len=8); assert rst_n=0 after 3 beats. Expect busy=0 immediately and no done pulse; a read of addresses 0..2 then returns the 3 written values.
- Write then read with wrap: write cmd_addr=62, cmd_len=3, data 0xA0..0xA3, then read the same range with rd_ready=1. Expect RAM addresses 62, 63, 0, 1 written; read data A0, A1, A2, A3, one per cycle after 1-cycle latency; exactly one done pulse per burst.
- Write stalls: write 4 beats with wr_valid low on alternating cycles. Expect ram_write high only on valid cycles, the address advancing only on accepted beats, and done one cycle after the 4th beat.
- Read backpressure: read 3 beats from address 0 (data 01/02/03) with rd_ready low for 2 cycles on beat 2. Expect rd_data=02 held stable with rd_valid=1 and ram_addr held at 1; the final sequence is 01, 02, 03.
- Full-depth burst: write 64 beats of data i^0x5A starting at address 17, then read 64 beats from address 17. Expect all values to match and cmd_ready=0 throughout both bursts.
- With RAM_BURST_BOUND_CHECK_EN defined: issue cmd_addr=62, cmd_len=3. Expect an err pulse, no ram_write activity, no done pulse, and cmd_ready=1 on the next cycle.
